// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor controller around one shared
// decoder-based 1-bit full-adder/full-subtractor cell, processed LSB-first.

// 1-bit cell: 3-to-8 minterm decode of {a,b,c}, outputs are OR-planes.
module serial_addsub_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic s,
  output logic cn
);
  logic [2:0] sel;
  logic [7:1] m;  // minterm 0 drives no output plane, so it is not decoded

  assign sel = {a, b, c};

  for (genvar i = 1; i < 8; i++) begin : g_dec
    assign m[i] = (sel == 3'(i));
  end

  // sum and difference share one plane; mode only picks carry vs borrow
  always_comb begin
    s  = m[1] | m[2] | m[4] | m[7];
    cn = mode ? (m[1] | m[2] | m[3] | m[7])
              : (m[3] | m[5] | m[6] | m[7]);
  end
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // latched request; a/b fields double as LSB-first shift registers
  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  req_t             req_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cy_q;
  logic [WIDTH-2:0] acc_q;   // upper bits of the partial result
  logic [WIDTH-1:0] acc_nxt; // partial result after this cycle's shift
  logic             s_bit, cy_nxt;
  logic             last_bit;

  serial_addsub_cell u_cell (
    .a    (req_q.a[0]),
    .b    (req_q.b[0]),
    .c    (cy_q),
    .mode (req_q.mode),
    .s    (s_bit),
    .cn   (cy_nxt)
  );

  // new bit enters at MSB; after WIDTH shifts bit i sits at position i
  assign acc_nxt  = {s_bit, acc_q};
  assign last_bit = (cnt_q == LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state and status outputs; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // operand latch, bit sequencing and carry/borrow chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      cnt_q <= '0;
      cy_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          req_q <= '{mode: mode, a: a, b: b};
          cnt_q <= '0;
          cy_q  <= 1'b0;
        end
        RUN: begin
          req_q.a <= req_q.a >> 1;
          req_q.b <= req_q.b >> 1;
          acc_q   <= acc_nxt[WIDTH-1:1];
          cy_q    <= cy_nxt;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // result/cout only load on the final bit so partial sums never show
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      result <= acc_nxt;
      cout   <= cy_nxt;
    end
  end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench: WIDTH=8 directed/random ops plus exhaustive WIDTH=4 sweep.
module tb_serial_addsub_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] res8;
  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] res4;

  int checks = 0;
  int errors = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] e8;
  logic [4:0] e4;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8));

  serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // reference: 9-bit add/sub; bit 8 is carry or borrow
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic m);
    return m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic m);
    return m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  endfunction

  // scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      chk("sb8_nonempty", 32'(q8.size() > 0), 1);
      chk("busy8_at_done", busy8, 0);
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        chk("res8", res8, e8[7:0]);
        chk("cout8", cout8, e8[8]);
      end
    end
    if (done4 === 1'b1) begin
      chk("sb4_nonempty", 32'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        chk("res4", res4, e4[3:0]);
        chk("cout4", cout4, e4[4]);
      end
    end
  end

  // drive a start at a negedge and record the expected outcome
  task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic m);
    @(negedge clk);
    a8 = x; b8 = y; mode8 = m; start8 = 1'b1;
    q8.push_back(ref8(x, y, m));
  endtask

  // from the start edge, count cycles until done (start edge's next cycle = 1)
  task automatic wait8(input int w);
    int n, bc;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n = 1; bc = 0;
    while (done8 !== 1'b1 && n <= 30) begin
      if (busy8 === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk("lat8", n, w + 1);
    chk("busy8_cycles", bc, w);
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic m);
    launch8(x, y, m);
    wait8(8);
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic m);
    int n, bc;
    @(negedge clk);
    a4 = x; b4 = y; mode4 = m; start4 = 1'b1;
    q4.push_back(ref4(x, y, m));
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    n = 1; bc = 0;
    while (done4 !== 1'b1 && n <= 30) begin
      if (busy4 === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk("lat4", n, 5);
    chk("busy4_cycles", bc, 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_res", res8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_res4", {busy4, done4, cout4, res4}, 0);
    rst = 1'b0;

    // directed add/sub
    run8(8'h5A, 8'h3C, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hFF, 8'hFF, 1'b0);
    run8(8'h10, 8'h01, 1'b1);
    run8(8'h00, 8'h01, 1'b1);
    run8(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 8; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom));

    // starts during RUN and DONE are ignored; start in IDLE right after is taken
    launch8(8'h21, 8'h13, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; mode8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ign_run_busy", busy8, 1);
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("ign_done_seen", done8, 1);
    a8 = 8'h77; b8 = 8'h11; mode8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    chk("ign_idle_busy", busy8, 0);
    chk("ign_idle_done", done8, 0);
    chk("ign_res_hold", res8, 8'h34);
    a8 = 8'h0C; b8 = 8'h05; mode8 = 1'b1;
    q8.push_back(ref8(8'h0C, 8'h05, 1'b1));
    wait8(8);

    // async reset at bit 4 of an add aborts it with no done
    launch8(8'h5A, 8'h3C, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy8, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_res", res8, 0);
    chk("arst_cout", cout8, 0);
    q8.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", {busy8, done8, cout8, res8}, 0);
    run8(8'hC8, 8'h64, 1'b1);

    // exhaustive WIDTH=4 sweep
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run4(4'(x), 4'(y), 1'(m));

    repeat (3) @(negedge clk);
    chk("sb8_drained", q8.size(), 0);
    chk("sb4_drained", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
